// File: rtl/hdmi_fb_pkg.sv
// hdmi_fb_pkg
// Shared definitions for the HDMI frame-buffer path: default frame
// dimensions (also used by the HDMI controller), the rectangle-fill FSM
// state type and the rectangle command record.
// No ports (package).
package hdmi_fb_pkg;

  localparam int FB_WIDTH_DEF  = 1280;
  localparam int FB_HEIGHT_DEF = 720;
  localparam int DATA_W_DEF    = 16;
  localparam int X_W_DEF       = $clog2(FB_WIDTH_DEF);
  localparam int Y_W_DEF       = $clog2(FB_HEIGHT_DEF);
  localparam int ADDR_W_DEF    = $clog2(FB_WIDTH_DEF * FB_HEIGHT_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } rect_state_t;

  // Field widths follow the default frame geometry.
  typedef struct packed {
    logic [X_W_DEF-1:0]    x;
    logic [Y_W_DEF-1:0]    y;
    logic [X_W_DEF-1:0]    w;
    logic [Y_W_DEF-1:0]    h;
    logic [DATA_W_DEF-1:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/fb_rect_clip.sv
// fb_rect_clip
// Combinational bounds policy for the rectangle-fill engine. Turns the
// registered command geometry into the effective exclusive end column and
// end line, plus an "empty" flag (nothing to write) and an error flag.
//
// Build option: FB_RECT_FILL_CLIP_EN
//   defined   - clamp the rectangle to the frame; off-frame origin gives an
//               empty rectangle; error flags any clamping/emptying.
//   undefined - any rectangle reaching past the frame is rejected whole.
//
// Ports:
//   x_i, y_i     : top-left corner
//   w_i, h_i     : size in pixels / lines
//   x_end_o      : effective exclusive end column (X_W+1 bits, never wraps)
//   y_end_o      : effective exclusive end line   (Y_W+1 bits, never wraps)
//   empty_o      : no pixel is to be written
//   err_o        : command exceeded the frame bounds
module fb_rect_clip
  import hdmi_fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int X_W       = $clog2(FB_WIDTH),
  parameter int Y_W       = $clog2(FB_HEIGHT)
) (
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W:0]   x_end_o,
  output logic [Y_W:0]   y_end_o,
  output logic           empty_o,
  output logic           err_o
);

  localparam logic [X_W:0] FB_W_L = FB_WIDTH[X_W:0];
  localparam logic [Y_W:0] FB_H_L = FB_HEIGHT[Y_W:0];

  logic [X_W:0] x_end_raw;
  logic [Y_W:0] y_end_raw;
  logic         zero_size;

  // One extra bit on each sum so x+w and y+h cannot wrap.
  assign x_end_raw = {1'b0, x_i} + {1'b0, w_i};
  assign y_end_raw = {1'b0, y_i} + {1'b0, h_i};
  assign zero_size = (w_i == '0) || (h_i == '0);

`ifdef FB_RECT_FILL_CLIP_EN
  logic x_oob;
  logic y_oob;
  logic x_clamp;
  logic y_clamp;

  always_comb begin
    x_oob   = ({1'b0, x_i} >= FB_W_L);
    y_oob   = ({1'b0, y_i} >= FB_H_L);
    x_clamp = (x_end_raw > FB_W_L);
    y_clamp = (y_end_raw > FB_H_L);
    x_end_o = x_clamp ? FB_W_L : x_end_raw;
    y_end_o = y_clamp ? FB_H_L : y_end_raw;
    empty_o = x_oob || y_oob || zero_size;
    err_o   = x_oob || y_oob || x_clamp || y_clamp;
  end
`else
  logic over;

  always_comb begin
    over    = (x_end_raw > FB_W_L) || (y_end_raw > FB_H_L);
    x_end_o = x_end_raw;
    y_end_o = y_end_raw;
    empty_o = over || zero_size;
    err_o   = over;
  end
`endif

endmodule

// File: rtl/fb_rect_fill.sv
// fb_rect_fill
// Rectangle-fill engine driving the frame-buffer pixel write port of the
// HDMI controller. Accepts one command over valid/ready, then emits one
// write per clock in raster order until the rectangle is painted, followed
// by a one-cycle done pulse (with err on bounds violation).
//
// Build option: FB_RECT_FILL_CLIP_EN (bounds policy, see fb_rect_clip).
//
// Ports:
//   clk_i        : system clock, rising edge
//   rst_n_i      : asynchronous active-low reset
//   cmd_valid_i  : command present
//   cmd_ready_o  : engine idle (decoded from state)
//   cmd_x_i/y_i  : top-left corner
//   cmd_w_i/h_i  : width in pixels / height in lines
//   cmd_color_i  : fill value
//   pxl_en_o     : write strobe (registered)
//   pxl_addr_o   : linear address y*FB_WIDTH + x (registered)
//   pxl_data_o   : write data (registered)
//   busy_o       : not idle (decoded from state)
//   done_o       : one-cycle completion pulse (registered)
//   err_o        : bounds error, coincident with done_o (registered)
module fb_rect_fill
  import hdmi_fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int X_W       = $clog2(FB_WIDTH),
  parameter int Y_W       = $clog2(FB_HEIGHT),
  parameter int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [X_W-1:0]    cmd_x_i,
  input  logic [Y_W-1:0]    cmd_y_i,
  input  logic [X_W-1:0]    cmd_w_i,
  input  logic [Y_W-1:0]    cmd_h_i,
  input  logic [DATA_W-1:0] cmd_color_i,
  output logic              pxl_en_o,
  output logic [ADDR_W-1:0] pxl_addr_o,
  output logic [DATA_W-1:0] pxl_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] FB_W_A = FB_WIDTH[ADDR_W-1:0];

  rect_state_t       state_q, state_d;
  rect_cmd_t         cmd_q, cmd_d;
  logic [X_W:0]      x_end_q, x_end_d;
  logic [Y_W:0]      y_end_q, y_end_d;
  logic              err_lat_q, err_lat_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [X_W-1:0]    col_q, col_d;
  logic [Y_W-1:0]    line_q, line_d;
  logic              pxl_en_q, pxl_en_d;
  logic [ADDR_W-1:0] pxl_addr_q, pxl_addr_d;
  logic [DATA_W-1:0] pxl_data_q, pxl_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [X_W:0]      clip_x_end;
  logic [Y_W:0]      clip_y_end;
  logic              clip_empty;
  logic              clip_err;

  logic [ADDR_W-1:0] row_setup;
  logic [X_W:0]      col_inc;
  logic [Y_W:0]      line_inc;
  logic              col_last;
  logic              line_last;

  fb_rect_clip #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .X_W       (X_W),
    .Y_W       (Y_W)
  ) u_clip (
    .x_i     (cmd_q.x),
    .y_i     (cmd_q.y),
    .w_i     (cmd_q.w),
    .h_i     (cmd_q.h),
    .x_end_o (clip_x_end),
    .y_end_o (clip_y_end),
    .empty_o (clip_empty),
    .err_o   (clip_err)
  );

  // Start-of-rectangle row address; captured into row_base_q in SETUP.
  assign row_setup = ADDR_W'(cmd_q.y) * FB_W_A;

  // col_q/line_q track the pixel currently on the write port, so the last
  // column/line test looks one ahead against the exclusive end.
  assign col_inc   = {1'b0, col_q} + {{X_W{1'b0}}, 1'b1};
  assign line_inc  = {1'b0, line_q} + {{Y_W{1'b0}}, 1'b1};
  assign col_last  = (col_inc == x_end_q);
  assign line_last = (line_inc == y_end_q);

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign pxl_en_o    = pxl_en_q;
  assign pxl_addr_o  = pxl_addr_q;
  assign pxl_data_o  = pxl_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    err_lat_d  = err_lat_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    line_d     = line_q;
    pxl_en_d   = 1'b0;
    pxl_addr_d = pxl_addr_q;
    pxl_data_d = pxl_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d.x     = cmd_x_i;
          cmd_d.y     = cmd_y_i;
          cmd_d.w     = cmd_w_i;
          cmd_d.h     = cmd_h_i;
          cmd_d.color = cmd_color_i;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        x_end_d    = clip_x_end;
        y_end_d    = clip_y_end;
        err_lat_d  = clip_err;
        row_base_d = row_setup;
        col_d      = cmd_q.x;
        line_d     = cmd_q.y;
        if (clip_empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = clip_err;
        end else begin
          // First pixel is launched straight out of SETUP so writes start
          // the cycle after it with no bubble.
          state_d    = ST_FILL;
          pxl_en_d   = 1'b1;
          pxl_addr_d = row_setup + ADDR_W'(cmd_q.x);
          pxl_data_d = cmd_q.color;
        end
      end

      ST_FILL: begin
        if (col_last && line_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = err_lat_q;
        end else if (col_last) begin
          col_d      = cmd_q.x;
          line_d     = line_inc[Y_W-1:0];
          row_base_d = row_base_q + FB_W_A;
          pxl_en_d   = 1'b1;
          pxl_addr_d = row_base_q + FB_W_A + ADDR_W'(cmd_q.x);
        end else begin
          col_d      = col_inc[X_W-1:0];
          pxl_en_d   = 1'b1;
          pxl_addr_d = row_base_q + ADDR_W'(col_inc[X_W-1:0]);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      err_lat_q  <= 1'b0;
      row_base_q <= '0;
      col_q      <= '0;
      line_q     <= '0;
      pxl_en_q   <= 1'b0;
      pxl_addr_q <= '0;
      pxl_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      err_lat_q  <= err_lat_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      line_q     <= line_d;
      pxl_en_q   <= pxl_en_d;
      pxl_addr_q <= pxl_addr_d;
      pxl_data_q <= pxl_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill
// Self-checking bench for fb_rect_fill: a table of rectangle commands run
// through a reference write generator feeding a scoreboard queue, plus
// hand-written sequences for back-to-back commands and mid-fill reset.
// Honours FB_RECT_FILL_CLIP_EN in its reference model.
module tb_fb_rect_fill;

  localparam int W = 1280;
  localparam int H = 720;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_x;
  logic [9:0]  cmd_y;
  logic [10:0] cmd_w;
  logic [9:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        pxl_en;
  logic [19:0] pxl_addr;
  logic [15:0] pxl_data;
  logic        busy;
  logic        done;
  logic        err;

  fb_rect_fill dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_x_i     (cmd_x),
    .cmd_y_i     (cmd_y),
    .cmd_w_i     (cmd_w),
    .cmd_h_i     (cmd_h),
    .cmd_color_i (cmd_color),
    .pxl_en_o    (pxl_en),
    .pxl_addr_o  (pxl_addr),
    .pxl_data_o  (pxl_data),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          k;
  } wr_t;

  typedef struct {
    int          x;
    int          y;
    int          w;
    int          h;
    logic [15:0] color;
    logic        exp_err;
    string       nm;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;
  int   t_hs     = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, ncyc);
    end
  endtask

  // Reference raster generator: pushes the expected writes, k = write index.
  task automatic push_expected(input int x, input int y, input int w, input int h,
                               input logic [15:0] c, output int n);
    int ex;
    int ey;
    n  = 0;
    ex = x + w;
    ey = y + h;
`ifdef FB_RECT_FILL_CLIP_EN
    if (x >= W || y >= H) return;
    if (ex > W) ex = W;
    if (ey > H) ey = H;
`else
    if (ex > W || ey > H) return;
`endif
    for (int yy = y; yy < ey; yy++) begin
      for (int xx = x; xx < ex; xx++) begin
        exp_q.push_back('{addr: yy * W + xx, data: c, k: n});
        n++;
      end
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard,
  // both in content and in the cycle it appears.
  always @(negedge clk) begin
    wr_t e;
    ncyc = ncyc + 1;
    if (pxl_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {12'd0, pxl_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {12'd0, pxl_addr}, e.addr);
        check("wr_data", {16'd0, pxl_data}, {16'd0, e.data});
        check("wr_cycle", ncyc - t_hs, 2 + e.k);
      end
    end
    if (err === 1'b1 && done !== 1'b1) check("err_without_done", {31'd0, done}, 1);
  end

  task automatic drive_cmd(input int x, input int y, input int w, input int h,
                           input logic [15:0] c);
    int g;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    check("ready_before_cmd", {31'd0, cmd_ready}, 1);
    cmd_x     = x[10:0];
    cmd_y     = y[9:0];
    cmd_w     = w[10:0];
    cmd_h     = h[9:0];
    cmd_color = c;
    cmd_valid = 1'b1;
    @(negedge clk); #1;
    t_hs = ncyc - 1;
    check("accepted_ready_low", {31'd0, cmd_ready}, 0);
    check("accepted_busy", {31'd0, busy}, 1);
  endtask

  task automatic wait_done(input int n, input logic exp_err, input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < n + 20; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      check({nm, "_done_timeout"}, 0, 1);
    end else begin
      check({nm, "_done_cycle"}, ncyc - t_hs, 2 + n);
      check({nm, "_err"}, {31'd0, err}, {31'd0, exp_err});
      check({nm, "_writes_left"}, exp_q.size(), 0);
      @(negedge clk); #1;
      check({nm, "_done_pulse"}, {31'd0, done}, 0);
      check({nm, "_ready_back"}, {31'd0, cmd_ready}, 1);
      check({nm, "_idle"}, {31'd0, busy}, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int na;
    int nb;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;

    vecs[0] = '{x: 0,    y: 0,   w: 4,  h: 2,   color: 16'hF800, exp_err: 1'b0, nm: "basic4x2"};
    vecs[1] = '{x: 10,   y: 3,   w: 0,  h: 5,   color: 16'h1234, exp_err: 1'b0, nm: "w_zero"};
    vecs[2] = '{x: 1278, y: 719, w: 4,  h: 3,   color: 16'hABCD, exp_err: 1'b1, nm: "corner_over"};
    vecs[3] = '{x: 1279, y: 0,   w: 1,  h: 720, color: 16'h0F0F, exp_err: 1'b0, nm: "last_col"};
    vecs[4] = '{x: 100,  y: 200, w: 7,  h: 3,   color: 16'h5A5A, exp_err: 1'b0, nm: "mid7x3"};
    vecs[5] = '{x: 5,    y: 5,   w: 3,  h: 0,   color: 16'h0001, exp_err: 1'b0, nm: "h_zero"};
    vecs[6] = '{x: 1270, y: 710, w: 10, h: 10,  color: 16'hFFFF, exp_err: 1'b0, nm: "exact_fit"};
    vecs[7] = '{x: 1500, y: 0,   w: 2,  h: 1,   color: 16'h7777, exp_err: 1'b1, nm: "x_offframe"};

    repeat (3) @(negedge clk);
    #1;
    check("rst_pxl_en",    {31'd0, pxl_en},    0);
    check("rst_pxl_addr",  {12'd0, pxl_addr},  0);
    check("rst_pxl_data",  {16'd0, pxl_data},  0);
    check("rst_done",      {31'd0, done},      0);
    check("rst_err",       {31'd0, err},       0);
    check("rst_busy",      {31'd0, busy},      0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    rst_n = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      push_expected(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color, n);
      drive_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color);
      cmd_valid = 1'b0;
      wait_done(n, vecs[i].exp_err, vecs[i].nm);
    end

    // Second command held on valid while the first one fills.
    push_expected(20, 30, 3, 2, 16'h07E0, na);
    drive_cmd(20, 30, 3, 2, 16'h07E0);
    cmd_x     = 11'd0;
    cmd_y     = 10'd1;
    cmd_w     = 11'd2;
    cmd_h     = 10'd1;
    cmd_color = 16'h001F;
    begin
      bit found;
      found = 0;
      for (int i = 0; i < na + 20; i++) begin
        @(negedge clk); #1;
        if (done === 1'b1) begin
          found = 1;
          break;
        end
        check("b2b_ready_low", {31'd0, cmd_ready}, 0);
      end
      if (!found) begin
        check("b2b_first_done_timeout", 0, 1);
      end else begin
        check("b2b_first_done_cycle", ncyc - t_hs, 2 + na);
        check("b2b_ready_low_at_done", {31'd0, cmd_ready}, 0);
        push_expected(0, 1, 2, 1, 16'h001F, nb);
        t_hs = ncyc + 1;
        @(negedge clk); #1;
        check("b2b_ready_after_done", {31'd0, cmd_ready}, 1);
        @(negedge clk); #1;
        check("b2b_second_accepted", {31'd0, cmd_ready}, 0);
        cmd_valid = 1'b0;
        wait_done(nb, 1'b0, "b2b_second");
      end
    end
    cmd_valid = 1'b0;

    // Reset asserted asynchronously after the third write of a 10x10 fill.
    push_expected(0, 0, 10, 10, 16'hC0DE, n);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    drive_cmd(0, 0, 10, 10, 16'hC0DE);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rstfill_third_write_en", {31'd0, pxl_en}, 1);
    check("rstfill_three_seen", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("rstfill_en_async",    {31'd0, pxl_en},    0);
    check("rstfill_addr_async",  {12'd0, pxl_addr},  0);
    check("rstfill_busy_async",  {31'd0, busy},      0);
    check("rstfill_ready_async", {31'd0, cmd_ready}, 1);
    check("rstfill_done_async",  {31'd0, done},      0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check("rstfill_ready_after", {31'd0, cmd_ready}, 1);
    check("rstfill_busy_after",  {31'd0, busy},      0);
    check("rstfill_no_done",     {31'd0, done},      0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Rectangle-fill engine feeding the pixel write port (`pxl_addr_i`/`pxl_data_i`/`pxl_en_i`) of the ADV7511 HDMI controller's frame buffer. It accepts one rectangle command at a time over a valid/ready handshake. It then emits one frame-buffer write per clock, in raster order, until the rectangle is painted. It runs in the system clock domain (`clk_s`) and is the upstream producer of all frame-buffer content.

## Interface
Parameters:
- `FB_WIDTH`, 1280: frame-buffer width in pixels.
- `FB_HEIGHT`, 720: frame-buffer height in lines.
- `DATA_W`, 16: pixel word width; matches `hdmi_d_o`.
- `X_W`, `$clog2(FB_WIDTH)` (11): width of x and w fields.
- `Y_W`, `$clog2(FB_HEIGHT)` (10): width of y and h fields.
- `ADDR_W`, `$clog2(FB_WIDTH*FB_HEIGHT)` (20): write-address width.

Ports:
- `clk_i` in 1: system clock. One clock; all logic is on its rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: engine idle; command accepted when `cmd_valid_i && cmd_ready_o`.
- `cmd_x_i` in X_W: left column.
- `cmd_y_i` in Y_W: top line.
- `cmd_w_i` in X_W: width in pixels.
- `cmd_h_i` in Y_W: height in lines.
- `cmd_color_i` in DATA_W: fill value.
- `pxl_en_o` out 1: write strobe.
- `pxl_addr_o` out ADDR_W: linear address, computed as y*FB_WIDTH + x.
- `pxl_data_o` out DATA_W: write data.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when a command completes.
- `err_o` out 1: one-cycle pulse coincident with `done_o` when the command exceeded the frame bounds.

## Operation
- FSM states: IDLE, SETUP, FILL, DONE. The FSM resets to IDLE.
- **IDLE.** `cmd_ready_o`=1. On handshake, register the command fields and go to SETUP.
- **SETUP (1 cycle).**
  - Compute `x_end = x+w` (X_W+1 bits) and `y_end = y+h` (Y_W+1 bits). These sums must never wrap.
  - Apply the bounds policy (see Configuration).
  - Compute `row_base = y*FB_WIDTH` (registered multiply) and load the column and line counters.
  - If the effective w==0 or h==0, go to DONE with no writes. Otherwise go to FILL.
- **FILL.**
  - Each cycle: `pxl_en_o`=1, `pxl_addr_o = row_base + col`, `pxl_data_o` = latched color, and `col` increments.
  - At `col == x_end-1`: wrap `col` to x, add FB_WIDTH to `row_base`, and increment the line counter.
  - After the write at the last column of the last line, go to DONE.
- **DONE (1 cycle).** `done_o`=1 and `err_o` per policy. Go to IDLE.
- Commands are never queued. `cmd_ready_o` is low from SETUP through DONE.
- All outputs are registered except `cmd_ready_o` and `busy_o`, which decode the state register.
- Reset values: `pxl_en_o`=0, `pxl_addr_o`=0, `pxl_data_o`=0, `done_o`=0, `err_o`=0, `busy_o`=0, `cmd_ready_o`=1.
- Reset asserted mid-FILL: all outputs take their reset values asynchronously. A partially painted rectangle remains in memory; this is not an error.

## Timing
- Handshake at edge T. SETUP occupies T+1.
- First write is visible in cycle T+2. Writes occupy W·H contiguous cycles with no gaps.
- `done_o` is asserted in cycle T+2+W·H. `cmd_ready_o` returns high at T+3+W·H.
- Empty command: `done_o` at T+2, no writes.
- Throughput: one pixel per clock. There is no back-pressure from the controller.

## Configuration
- The macro is `FB_RECT_FILL_CLIP_EN`.
- **Defined:**
  - Clamp `x_end` to FB_WIDTH and `y_end` to FB_HEIGHT.
  - If x ≥ FB_WIDTH or y ≥ FB_HEIGHT, the rectangle is empty.
  - Only in-frame pixels are written.
  - `err_o` pulses if any clamping or emptying occurred.
- **Undefined:**
  - Any command with `x_end` > FB_WIDTH or `y_end` > FB_HEIGHT is rejected whole: zero writes, then DONE with `err_o`=1.
  - The clamp logic is absent.

## Structure
- Shared package `hdmi_fb_pkg` holds:
  - the state enum `rect_state_t`;
  - the struct `rect_cmd_t` (x, y, w, h, color);
  - the localparam defaults for the frame dimensions, shared with the HDMI controller.
- One sub-module: `fb_rect_clip`, combinational. It takes the registered command and produces the effective x_end/y_end, an empty flag and an error flag. The macro is confined to this sub-module.

## Test plan
- x=0,y=0,w=4,h=2,color=16'hF800 → 8 writes at addresses 0,1,2,3,1280,1281,1282,1283 in T+2..T+9, all with data F800; `done_o` at T+10, `err_o`=0.
- w=0,h=5 → no `pxl_en_o`; `done_o` at T+2, `err_o`=0.
- x=1278,y=719,w=4,h=3:
  - with macro → 2 writes at 921598 and 921599; `done_o` and `err_o`=1 at T+4.
  - without macro → 0 writes; `done_o` and `err_o`=1 at T+2.
- `cmd_valid_i` held high with a second command during FILL → `cmd_ready_o`=0 until the cycle after `done_o`; the second command is accepted at done+1 and its first write appears 2 cycles later.
- `rst_n_i` low asynchronously after the 3rd write of a 10×10 fill → `pxl_en_o` drops before the next edge. After release: IDLE, `cmd_ready_o`=1, no further writes.
- x=1279,y=0,w=1,h=720 → 720 writes at address 1279 + k·1280, k=0..719; the last write is at 921599. `err_o`=0.
